// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU op codes, MemReg selects and
// the decode control bundle carried from ID into EX.
package mips_pkg;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned MEMREG_W = 2;
  localparam int unsigned REGDST_W = 2;

  // Primary opcodes
  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALUOP_W-1:0] ALU_BEQ = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALU_BNE = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'b1000;

  // Writeback source select
  localparam logic [MEMREG_W-1:0] MEMREG_ALU = 2'd0;
  localparam logic [MEMREG_W-1:0] MEMREG_MEM = 2'd1;
  localparam logic [MEMREG_W-1:0] MEMREG_PC4 = 2'd2;

  // Decode control bundle (14 bits); all-zero is a harmless bubble
  typedef struct packed {
    logic [REGDST_W-1:0] regdst;
    logic                jump;
    logic                branch;
    logic                memread;
    logic [MEMREG_W-1:0] memreg;
    logic                alusrc;
    logic                regwrite;
    logic                memwrite;
    logic [ALUOP_W-1:0]  aluop;
  } ctrl_bundle_t;

  localparam int unsigned CTRL_W = $bits(ctrl_bundle_t);

endpackage

// File: rtl/id_ex_stage_hazard.sv
// hazard_detect: combinational load-use detection for the ID/EX register.
// Ports: id_opcode/id_rs/id_rt describe the instruction in ID; ex_valid,
// ex_memread, ex_rt describe the instruction in EX; flush/ex_hold are the
// pipeline controls. load_use_c and stall_c are combinational results.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              load_use_c,
  output logic              stall_c
);

  logic uses_rs;
  logic uses_rt;

  // Source-operand usage by opcode: J reads nothing, I-types read rs only
  always_comb begin
    uses_rs = (id_opcode != OP_J);
    uses_rt = (id_opcode == OP_RTYPE) || (id_opcode == OP_BEQ) ||
              (id_opcode == OP_BNE)   || (id_opcode == OP_SW);
  end

  // A load into $zero never creates a real dependency
  always_comb begin
    load_use_c = ex_valid && ex_memread && (ex_rt != '0) &&
                 ((uses_rs && (ex_rt == id_rs)) || (uses_rt && (ex_rt == id_rt)));
    stall_c    = !flush && (load_use_c || ex_hold);
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion,
// flush, EX hold and a saturating count of inserted load-use bubbles.
// Ports: id_* decode outputs in; ex_* registered copies out; ex_valid marks a
// real instruction; stall (combinational) freezes PC and IF/ID; stall_count
// counts load-use bubbles.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        id_opcode,
  input  logic [1:0]        id_regdst,
  input  logic              id_jump,
  input  logic              id_branch,
  input  logic              id_memread,
  input  logic [1:0]        id_memreg,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              id_memwrite,
  input  logic [3:0]        id_aluop,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              flush,
  input  logic              ex_hold,
  output logic [1:0]        ex_regdst,
  output logic              ex_jump,
  output logic              ex_branch,
  output logic              ex_memread,
  output logic [1:0]        ex_memreg,
  output logic              ex_alusrc,
  output logic              ex_regwrite,
  output logic              ex_memwrite,
  output logic [3:0]        ex_aluop,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic              ex_valid,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  ctrl_bundle_t      id_ctrl;
  ctrl_bundle_t      ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic [DATA_W-1:0] imm_q, imm_d, pc4_q, pc4_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_use;
  logic              stall_c;

  always_comb begin
    id_ctrl = '{regdst:   id_regdst,   jump:     id_jump,
                branch:   id_branch,   memread:  id_memread,
                memreg:   id_memreg,   alusrc:   id_alusrc,
                regwrite: id_regwrite, memwrite: id_memwrite,
                aluop:    id_aluop};
  end

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .id_opcode  (id_opcode),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_valid   (valid_q),
    .ex_memread (ctrl_q.memread),
    .ex_rt      (rt_q),
    .flush      (flush),
    .ex_hold    (ex_hold),
    .load_use_c (load_use),
    .stall_c    (stall_c)
  );

  // Next-state: flush > hold > load-use bubble > normal load.
  // Bubbles clear only control and valid; data fields are left as-is.
  always_comb begin
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    pc4_d    = pc4_q;
    cnt_d    = cnt_q;
    if (flush) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (ex_hold) begin
      // retain everything
    end else if (load_use) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ctrl_d   = id_ctrl;
      valid_d  = 1'b1;
      rs_d     = id_rs;
      rt_d     = id_rt;
      rd_d     = id_rd;
      rdata1_d = id_rdata1;
      rdata2_d = id_rdata2;
      imm_d    = id_imm;
      pc4_d    = id_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
      cnt_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      pc4_q    <= pc4_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    ex_regdst   = ctrl_q.regdst;
    ex_jump     = ctrl_q.jump;
    ex_branch   = ctrl_q.branch;
    ex_memread  = ctrl_q.memread;
    ex_memreg   = ctrl_q.memreg;
    ex_alusrc   = ctrl_q.alusrc;
    ex_regwrite = ctrl_q.regwrite;
    ex_memwrite = ctrl_q.memwrite;
    ex_aluop    = ctrl_q.aluop;
    ex_rs       = rs_q;
    ex_rt       = rt_q;
    ex_rd       = rd_q;
    ex_rdata1   = rdata1_q;
    ex_rdata2   = rdata2_q;
    ex_imm      = imm_q;
    ex_pc4      = pc4_q;
    ex_valid    = valid_q;
    stall       = stall_c;
    stall_count = cnt_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios followed by
// random traffic, checked against a behavioural pipeline-register model.
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [5:0]  op;
    ctrl_bundle_t ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm, pc4;
    logic        flush, hold, rst_n;
  } stim_t;

  typedef struct {
    logic         stall;
    logic         valid;
    ctrl_bundle_t ctrl;
    logic [4:0]   rs, rt, rd;
    logic [31:0]  d1, d2, imm, pc4;
    int           cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] id_opcode;
  logic [1:0] id_regdst, id_memreg;
  logic id_jump, id_branch, id_memread, id_alusrc, id_regwrite, id_memwrite;
  logic [3:0] id_aluop;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
  logic flush, ex_hold;
  logic [1:0] ex_regdst, ex_memreg;
  logic ex_jump, ex_branch, ex_memread, ex_alusrc, ex_regwrite, ex_memwrite;
  logic [3:0] ex_aluop;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic ex_valid, stall;
  logic [CNT_W-1:0] stall_count;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode),
    .id_regdst(id_regdst), .id_jump(id_jump), .id_branch(id_branch),
    .id_memread(id_memread), .id_memreg(id_memreg), .id_alusrc(id_alusrc),
    .id_regwrite(id_regwrite), .id_memwrite(id_memwrite), .id_aluop(id_aluop),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
    .flush(flush), .ex_hold(ex_hold),
    .ex_regdst(ex_regdst), .ex_jump(ex_jump), .ex_branch(ex_branch),
    .ex_memread(ex_memread), .ex_memreg(ex_memreg), .ex_alusrc(ex_alusrc),
    .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite), .ex_aluop(ex_aluop),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_valid(ex_valid), .stall(stall), .stall_count(stall_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  exp_t exp_q[$];

  // Reference model: what EX currently holds
  logic         m_valid;
  ctrl_bundle_t m_ctrl;
  logic [4:0]   m_rs, m_rt, m_rd;
  logic [31:0]  m_d1, m_d2, m_imm, m_pc4;
  int           m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic [5:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [3:0] aluop, input logic regwrite,
                               input logic [1:0] regdst, input logic memread);
    stim_t s;
    s.op = op;
    s.ctrl = '0;
    s.ctrl.aluop = aluop;
    s.ctrl.regwrite = regwrite;
    s.ctrl.regdst = regdst;
    s.ctrl.memread = memread;
    s.ctrl.memreg = memread ? MEMREG_MEM : MEMREG_ALU;
    s.ctrl.alusrc = (op != OP_RTYPE);
    s.rs = rs; s.rt = rt; s.rd = rd;
    s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom; s.pc4 = $urandom;
    s.flush = 1'b0; s.hold = 1'b0; s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd();
    logic [5:0] ops [10];
    stim_t s;
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_BNE, OP_SLTI, OP_J};
    s.op = ops[$urandom_range(0, 9)];
    s.ctrl = CTRL_W'($urandom);
    s.ctrl.memread = (s.op == OP_LW) || ($urandom_range(0, 7) == 0);
    s.rs = 5'($urandom_range(0, 7));
    s.rt = 5'($urandom_range(0, 7));
    s.rd = 5'($urandom);
    s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom; s.pc4 = $urandom;
    s.flush = ($urandom_range(0, 9) == 0);
    s.hold  = ($urandom_range(0, 7) == 0);
    s.rst_n = ($urandom_range(0, 59) != 0);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst_n = s.rst_n; id_opcode = s.op;
    id_regdst = s.ctrl.regdst; id_jump = s.ctrl.jump; id_branch = s.ctrl.branch;
    id_memread = s.ctrl.memread; id_memreg = s.ctrl.memreg; id_alusrc = s.ctrl.alusrc;
    id_regwrite = s.ctrl.regwrite; id_memwrite = s.ctrl.memwrite; id_aluop = s.ctrl.aluop;
    id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
    id_rdata1 = s.d1; id_rdata2 = s.d2; id_imm = s.imm; id_pc4 = s.pc4;
    flush = s.flush; ex_hold = s.hold;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    m_d1 = '0; m_d2 = '0; m_imm = '0; m_pc4 = '0; m_cnt = 0;
  endtask

  // Present one ID instruction for one cycle; record what must be seen this
  // cycle, then advance the model across the coming clock edge.
  task automatic drive(input stim_t s);
    exp_t e;
    bit reads_rs, reads_rt, dep;
    apply(s);
    reads_rs = (s.op != OP_J);
    reads_rt = (s.op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW});
    dep = m_valid && m_ctrl.memread && (m_rt != 0) &&
          ((reads_rs && m_rt == s.rs) || (reads_rt && m_rt == s.rt));
    e.stall = !s.flush && (dep || s.hold);
    e.valid = m_valid; e.ctrl = m_ctrl; e.rs = m_rs; e.rt = m_rt; e.rd = m_rd;
    e.d1 = m_d1; e.d2 = m_d2; e.imm = m_imm; e.pc4 = m_pc4; e.cnt = m_cnt;
    exp_q.push_back(e);
    if (!s.rst_n) model_reset();
    else if (s.flush) begin m_valid = 1'b0; m_ctrl = '0; end
    else if (s.hold) begin end
    else if (dep) begin
      m_valid = 1'b0; m_ctrl = '0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_valid = 1'b1; m_ctrl = s.ctrl; m_rs = s.rs; m_rt = s.rt; m_rd = s.rd;
      m_d1 = s.d1; m_d2 = s.d2; m_imm = s.imm; m_pc4 = s.pc4;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: each mid-cycle, compare the DUT against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      ctrl_bundle_t dc;
      e = exp_q.pop_front();
      dc = '{regdst: ex_regdst, jump: ex_jump, branch: ex_branch, memread: ex_memread,
             memreg: ex_memreg, alusrc: ex_alusrc, regwrite: ex_regwrite,
             memwrite: ex_memwrite, aluop: ex_aluop};
      chk("stall", 64'(stall), 64'(e.stall));
      chk("ex_valid", 64'(ex_valid), 64'(e.valid));
      chk("ctrl", 64'(dc), 64'(e.ctrl));
      chk("stall_count", 64'(stall_count), 64'(e.cnt));
      if (e.valid) begin
        chk("ex_rs", 64'(ex_rs), 64'(e.rs));
        chk("ex_rt", 64'(ex_rt), 64'(e.rt));
        chk("ex_rd", 64'(ex_rd), 64'(e.rd));
        chk("ex_rdata1", 64'(ex_rdata1), 64'(e.d1));
        chk("ex_rdata2", 64'(ex_rdata2), 64'(e.d2));
        chk("ex_imm", 64'(ex_imm), 64'(e.imm));
        chk("ex_pc4", 64'(ex_pc4), 64'(e.pc4));
      end
    end
  end

  initial begin
    stim_t s;
    // Reset with nonzero inputs for two edges
    s = mk(OP_LW, 5'd1, 5'd5, 5'd9, ALU_SUB, 1'b1, 2'd1, 1'b1);
    s.rst_n = 1'b0;
    apply(s);
    model_reset();
    @(posedge clk); #1;
    drive(s);

    // ADD r3,r1,r2 pass-through
    drive(mk(OP_RTYPE, 5'd1, 5'd2, 5'd3, ALU_ADD, 1'b1, 2'd1, 1'b0));
    // LW r5 ; SUB r6,r5,r7 (stalls once, then loads)
    drive(mk(OP_LW, 5'd1, 5'd5, 5'd0, ALU_ADD, 1'b1, 2'd0, 1'b1));
    drive(mk(OP_RTYPE, 5'd5, 5'd7, 5'd6, ALU_SUB, 1'b1, 2'd1, 1'b0));
    drive(mk(OP_RTYPE, 5'd5, 5'd7, 5'd6, ALU_SUB, 1'b1, 2'd1, 1'b0));
    // LW r5 ; ADDI r8,r5 (rs match)
    drive(mk(OP_LW, 5'd2, 5'd5, 5'd0, ALU_ADD, 1'b1, 2'd0, 1'b1));
    drive(mk(OP_ADDI, 5'd5, 5'd8, 5'd0, ALU_ADD, 1'b1, 2'd0, 1'b0));
    drive(mk(OP_ADDI, 5'd5, 5'd8, 5'd0, ALU_ADD, 1'b1, 2'd0, 1'b0));
    // LW r5 ; J (no stall even though field bits alias r5)
    drive(mk(OP_LW, 5'd2, 5'd5, 5'd0, ALU_ADD, 1'b1, 2'd0, 1'b1));
    drive(mk(OP_J, 5'd5, 5'd5, 5'd0, ALU_ADD, 1'b0, 2'd0, 1'b0));
    // LW r0 ; ADD r1,r0,r0 (no stall)
    drive(mk(OP_LW, 5'd2, 5'd0, 5'd0, ALU_ADD, 1'b1, 2'd0, 1'b1));
    drive(mk(OP_RTYPE, 5'd0, 5'd0, 5'd1, ALU_ADD, 1'b1, 2'd1, 1'b0));
    // Flush together with load-use and hold
    drive(mk(OP_LW, 5'd2, 5'd5, 5'd0, ALU_ADD, 1'b1, 2'd0, 1'b1));
    s = mk(OP_RTYPE, 5'd5, 5'd7, 5'd6, ALU_SUB, 1'b1, 2'd1, 1'b0);
    s.flush = 1'b1; s.hold = 1'b1;
    drive(s);
    // Hold for three cycles over a pending load-use, then release
    drive(mk(OP_LW, 5'd2, 5'd5, 5'd0, ALU_ADD, 1'b1, 2'd0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      s = mk(OP_RTYPE, 5'd5, 5'd7, 5'd6, ALU_OR, 1'b1, 2'd1, 1'b0);
      s.hold = 1'b1;
      drive(s);
    end
    drive(mk(OP_RTYPE, 5'd5, 5'd7, 5'd6, ALU_OR, 1'b1, 2'd1, 1'b0));
    drive(mk(OP_RTYPE, 5'd5, 5'd7, 5'd6, ALU_OR, 1'b1, 2'd1, 1'b0));
    // Reset while a load-use stall is pending
    drive(mk(OP_LW, 5'd2, 5'd5, 5'd0, ALU_ADD, 1'b1, 2'd0, 1'b1));
    s = mk(OP_RTYPE, 5'd5, 5'd7, 5'd6, ALU_SUB, 1'b1, 2'd1, 1'b0);
    s.rst_n = 1'b0;
    drive(s);
    drive(mk(OP_RTYPE, 5'd5, 5'd7, 5'd6, ALU_SUB, 1'b1, 2'd1, 1'b0));
    // Drive the counter past saturation
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      drive(mk(OP_LW, 5'd2, 5'd4, 5'd0, ALU_ADD, 1'b1, 2'd0, 1'b1));
      drive(mk(OP_BEQ, 5'd1, 5'd4, 5'd0, ALU_BEQ, 1'b0, 2'd0, 1'b0));
      drive(mk(OP_BEQ, 5'd1, 5'd4, 5'd0, ALU_BEQ, 1'b0, 2'd0, 1'b0));
    end
    // Random traffic
    for (int i = 0; i < 3000; i++) drive(rnd());

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline; sits directly downstream of the decode control unit.
- Captures that unit's control bundle (RegDst, Jump, Branch, MemRead, MemReg, AluSrc, RegWrite, MemWrite, AluOp) plus operands, register indices and PC+4, and presents them to EX one cycle later.
- Contains load-use hazard detection: inserts bubbles and freezes PC and IF/ID.
- Supports branch/jump flush and an EX hold request; keeps a saturating stall counter.

Parameters:
DATA_W, 32, operand/immediate/PC width
REG_AW, 5, register index width
CNT_W, 16, stall counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
id_opcode  in  6  opcode of instruction in ID
id_regdst  in  2  control: RegDst
id_jump, id_branch, id_memread, id_alusrc, id_regwrite, id_memwrite  in  1 each  control bits
id_memreg  in  2  control: MemReg (0 ALU, 1 mem, 2 PC+4)
id_aluop  in  4  control: AluOp
id_rs, id_rt, id_rd  in  REG_AW  register indices
id_rdata1, id_rdata2, id_imm, id_pc4  in  DATA_W  operands, sign-extended immediate, PC+4
flush  in  1  branch/jump resolved taken in EX; kill ID instruction
ex_hold  in  1  EX requests freeze (multi-cycle op)
ex_* (same names/widths as id_* minus id_opcode)  out  registered copies
ex_valid  out  1  1 = real instruction, 0 = bubble
stall  out  1  combinational: freeze PC and IF/ID this cycle
stall_count  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset: all ex_* outputs, ex_valid and stall_count = 0 on the first clk edge with rst_n=0. A zero control bundle is a legal bubble (no write, no mem access).
- uses_rs = (id_opcode != J 6'b000010). uses_rt = opcode in {R-type 000000, BEQ 000100, BNE 000101, SW 101011}.
- load_use = ex_valid & ex_memread & (ex_rt != 0) & ((uses_rs & ex_rt==id_rs) | (uses_rt & ex_rt==id_rt)).
- stall = ~flush & (load_use | ex_hold). Combinational, no added latency.
- Per-edge priority:
  1. reset
  2. flush: load bubble (all controls 0, ex_valid=0); stall_count unchanged.
  3. ex_hold: retain all ex_* unchanged.
  4. load_use: load bubble; stall_count += 1, saturating at all-ones.
  5. otherwise: load all id_* into ex_*, ex_valid=1.
- Bubble clears only control bits and ex_valid; data/index fields may hold any value. The bench must check controls only.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- A load_use bubble lasts exactly one cycle: next cycle ex_memread=0, so stall drops and the held ID instruction loads.
- ex_hold and load_use together: hold wins, no bubble, no count. After hold releases, load_use is re-evaluated.
- flush with load_use: flush wins, stall=0, no count.
- Reset mid-stall: stall deasserts the cycle after reset is sampled (ex_valid=0).
- $zero destination (ex_rt=0) never triggers load_use.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_BNE, OP_SLTI, OP_J
  - ALU op constants: ALU_ADD 0000, SUB 0001, AND 0010, OR 0011, BEQ 0101, BNE 0110, SLT 0111, SLL 1000
  - MemReg select constants
  - a ctrl_bundle struct, 14 bits
- One sub-module, hazard_detect: purely combinational; computes uses_rs/uses_rt, load_use and stall.

Test Plan:
- Reset: drive nonzero id_* with rst_n=0 for 2 cycles -> all ex_* = 0, ex_valid=0, stall_count=0.
- Pass-through: ADD r3,r1,r2 (opcode 0, aluop 0000, regwrite 1, regdst 1) -> next cycle ex_aluop=0000, ex_regwrite=1, ex_rd=3, ex_valid=1, stall=0.
- Load-use:
  - LW r5 followed by SUB r6,r5,r7 -> stall=1 for exactly 1 cycle, ex_valid=0 in the bubble, stall_count=1.
  - SUB appears in EX the following cycle.
- No false stall:
  - LW r5 then ADDI r8,r5? -> stall=1 (rs match).
  - LW r5 then J -> stall=0.
  - LW r0 then ADD r1,r0,r0 -> stall=0.
- Flush priority: flush=1 together with load_use and ex_hold -> stall=0, next ex_valid=0, all controls 0, count unchanged.
- Hold plus saturation:
  - ex_hold=1 for 3 cycles -> ex_* frozen, stall=1, count unchanged.
  - With CNT_W=2, 5 load-use events -> stall_count=3.
